fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that shares one synchronous FIFO write port between NumReq independent producers.
- Grants the port to one requester at a time and forwards that requester's words to the FIFO, stalling on full.
- Releases the port after MaxBurst words, or earlier if the requester drops its request.
- Sits directly in front of fifo_sync's data_in/wr_en/full interface.

Parameters:
- Width, 8: data word width in bits; must match the FIFO's Width.
- NumReq, 4: number of requesters; must be 2 or more.
- MaxBurst, 4: maximum words transferred per grant; must be 1 or more.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  one clock; reset is synchronous and active-high.
- req  input  NumReq  per-requester write request; bit i belongs to requester i.
- req_data  input  NumReq*Width  packed request data; requester i uses bits [i*Width +: Width].
- ack  output  NumReq  one-hot; bit i high means requester i's word is written this cycle.
- grant  output  NumReq  one-hot current owner; all zero when idle.
- fifo_full  input  1  full flag from the FIFO.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_data_in  output  Width  FIFO write data.
- busy  output  1  high while in GRANT.

Behaviour:
- Reset (synchronous, takes priority over everything): state=IDLE, owner=0, rr_ptr=0, burst_cnt=0. Consequently grant=0, ack=0, fifo_wr_en=0, busy=0, fifo_data_in=0 on the cycle after reset is sampled.
- Reset mid-burst: the burst is abandoned, with no further writes. Words already acked are final.
- Registered state: state (IDLE/GRANT), owner (clog2(NumReq) bits), rr_ptr (clog2(NumReq) bits), burst_cnt (clog2(MaxBurst+1) bits).
- IDLE:
  - grant=0, no writes.
  - If any req bit is set, pick the first set bit scanning upward from rr_ptr and wrapping modulo NumReq.
  - Load owner with that index, clear burst_cnt, and go to GRANT on the next edge.
  - Arbitration latency is 1 cycle from IDLE.
- GRANT:
  - grant = one-hot(owner); busy=1.
  - Transfer (combinational, same cycle) = req[owner] && !fifo_full.
  - On a transfer: fifo_wr_en=1, fifo_data_in=req_data slice of owner, ack=one-hot(owner), burst_cnt increments at the edge.
  - With no transfer: fifo_wr_en=0, ack=0. fifo_data_in still shows the owner slice, and the value is don't-care.
- Exit from GRANT to IDLE happens on the next edge when either:
  - req[owner]=0 this cycle (no transfer this cycle), or
  - a transfer occurs with burst_cnt == MaxBurst-1 (the last word of the burst).
- On exit: rr_ptr <= owner+1, wrapping from NumReq-1 to 0.
- After every grant there is always exactly one IDLE cycle before the next grant. This holds even when the same requester is the only one pending.
- fifo_full held high in GRANT: the arbiter stalls indefinitely, keeps the grant, and leaves burst_cnt unchanged. There is no timeout.
- fifo_full and req[owner]=0 in the same cycle: exit, because the req drop wins.
- The arbiter never asserts fifo_wr_en while fifo_full=1, so no FIFO write is ever dropped.
- Requester contract:
  - Hold req_data stable while req is high.
  - A word is consumed only on an ack cycle; present the next word in the following cycle.
  - req may deassert at any time.
- Non-owner requesters see ack=0 and are not disturbed.
- Request changes on non-owners during GRANT have no effect until the next IDLE.

Test Plan:
- Reset with req=4'b1111 held 2 cycles -> grant=0, fifo_wr_en=0, ack=0 throughout. First cycle after release is IDLE. Next cycle grant=4'b0001.
- Only req[2] high continuously, words 0xA0,0xA1,... -> ack[2] on 4 consecutive cycles (FIFO gets 0xA0..0xA3), then 1 cycle with grant=0, then grant=4'b0100 again for 0xA4..0xA7.
- All four requesters continuous, requester i sends 0x10*i+k -> grant order 0,1,2,3,0. Each grant writes 4 words with a 1-cycle gap between grants. FIFO order is 0x00-0x03, 0x10-0x13, 0x20-0x23, 0x30-0x33.
- Owner req[0] continuous; fifo_full=1 for 3 cycles after 2 words -> fifo_wr_en=0, ack=0, grant stays 4'b0001 during the stall. Then 2 more words are written and the arbiter goes to IDLE.
- req[1] owns the port and drops req after 2 words while req[0] and req[3] are pending -> IDLE next cycle with rr_ptr=2. Grant then goes to requester 3 (4'b1000), not 0.
- Reset asserted during the 3rd word of a burst -> fifo_wr_en=0, grant=0, busy=0 next cycle. After release, arbitration restarts from requester 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one synchronous FIFO write port between NumReq producers.
// The owner keeps the port for up to MaxBurst words, stalls on full, and releases early if it drops req.
module fifo_wr_arbiter #(
   parameter int unsigned Width    = 8,
   parameter int unsigned NumReq   = 4,
   parameter int unsigned MaxBurst = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NumReq-1:0]        req,
   input  logic [NumReq*Width-1:0]  req_data,
   output logic [NumReq-1:0]        ack,
   output logic [NumReq-1:0]        grant,
   input  logic                     fifo_full,
   output logic                     fifo_wr_en,
   output logic [Width-1:0]         fifo_data_in,
   output logic                     busy
);

   localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
   localparam int unsigned CntW = $clog2(MaxBurst + 1);

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t            r_state;
   logic [PtrW-1:0]   r_owner;
   logic [PtrW-1:0]   r_rr_ptr;
   logic [CntW-1:0]   r_burst_cnt;

   logic [Width-1:0]  w_words [NumReq];
   logic [NumReq-1:0] w_owner_oh;
   logic [PtrW-1:0]   w_pick;
   logic [PtrW-1:0]   w_owner_next;
   logic              w_found;
   logic              w_owner_req;
   logic              w_xfer;
   logic              w_last;
   logic              w_exit;

   always_comb begin
      for (int i = 0; i < int'(NumReq); i++) begin
         w_words[i] = req_data[i*Width +: Width];
      end
   end

   // First pending requester scanning upward from r_rr_ptr, wrapping modulo NumReq.
   always_comb begin : b_pick
      int unsigned idx;
      idx     = 0;
      w_found = 1'b0;
      w_pick  = '0;
      for (int unsigned k = 0; k < NumReq; k++) begin
         idx = (32'(r_rr_ptr) + k) % NumReq;
         if (!w_found && req[PtrW'(idx)]) begin
            w_found = 1'b1;
            w_pick  = PtrW'(idx);
         end
      end
   end

   always_comb begin
      w_owner_oh   = NumReq'(1) << r_owner;
      w_owner_req  = req[r_owner];
      w_xfer       = (r_state == ST_GRANT) && w_owner_req && !fifo_full;
      w_last       = (r_burst_cnt == CntW'(MaxBurst - 1));
      w_exit       = !w_owner_req || (w_xfer && w_last);
      w_owner_next = (r_owner == PtrW'(NumReq - 1)) ? '0 : r_owner + PtrW'(1);
   end

   // The transfer is decided in the same cycle the FIFO sees full, so a write is never dropped.
   always_comb begin
      busy         = (r_state == ST_GRANT);
      grant        = busy ? w_owner_oh : '0;
      ack          = w_xfer ? w_owner_oh : '0;
      fifo_wr_en   = w_xfer;
      fifo_data_in = busy ? w_words[r_owner] : '0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_owner     <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_found) begin
                  r_owner     <= w_pick;
                  r_burst_cnt <= '0;
                  r_state     <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (w_xfer) begin
                  r_burst_cnt <= r_burst_cnt + CntW'(1);
               end
               if (w_exit) begin
                  r_state  <= ST_IDLE;
                  r_rr_ptr <= w_owner_next;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
